// File: rtl/micro_sequencer.sv
// micro_sequencer: loadable micro-program control unit with start/busy/done handshake
module micro_sequencer #(
  parameter int REG_ADDR_W = 3,
  parameter int ALU_OP_W = 3,
  parameter int PC_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cond,
  input  logic prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [2+1+3*REG_ADDR_W+ALU_OP_W-1:0] prog_wdata,
  output logic busy,
  output logic done,
  output logic [PC_W-1:0] pc,
  output logic RFSrcMuxSel,
  output logic [REG_ADDR_W-1:0] readAddr1,
  output logic [REG_ADDR_W-1:0] readAddr2,
  output logic [REG_ADDR_W-1:0] writeAddr,
  output logic writeEn,
  output logic outBuf,
  output logic [ALU_OP_W-1:0] aluOP
);
  localparam int INSTR_W = 2 + 1 + 3 * REG_ADDR_W + ALU_OP_W;
  localparam int R = REG_ADDR_W;
  if (PC_W > INSTR_W - 3) begin : g_bad_pc_w
    $error("micro_sequencer: PC_W too wide for instruction word");
  end
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t state;
  logic [INSTR_W-1:0] mem [2**PC_W];
  logic [INSTR_W-1:0] ir, fw;
  logic [1:0] ft, it;
  assign fw = mem[pc];
  assign ft = fw[INSTR_W-1 -: 2];
  assign it = ir[INSTR_W-1 -: 2];
  always_ff @(posedge clk)
    if (prog_we && state == IDLE) mem[prog_addr] <= prog_wdata;
  // Control outputs are loaded from the fetched word on the FETCH edge so they
  // are registered yet already valid for the whole EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      RFSrcMuxSel <= 1'b0;
      readAddr1 <= '0;
      readAddr2 <= '0;
      writeAddr <= '0;
      writeEn <= 1'b0;
      outBuf <= 1'b0;
      aluOP <= '0;
    end else begin
      done <= 1'b0;
      RFSrcMuxSel <= 1'b0;
      readAddr1 <= '0;
      readAddr2 <= '0;
      writeAddr <= '0;
      writeEn <= 1'b0;
      outBuf <= 1'b0;
      aluOP <= '0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          pc <= '0;
          busy <= 1'b1;
        end
        FETCH: begin
          ir <= fw;
          state <= EXEC;
          RFSrcMuxSel <= ft == 2'b00 && fw[INSTR_W-3];
          readAddr1 <= ft[1] ? '0 : fw[INSTR_W-4 -: R];
          readAddr2 <= ft == 2'b00 ? fw[INSTR_W-4-R -: R] : '0;
          writeAddr <= ft == 2'b00 ? fw[ALU_OP_W +: R] : '0;
          writeEn <= ft == 2'b00;
          outBuf <= ft == 2'b01;
          aluOP <= ft == 2'b00 ? fw[ALU_OP_W-1:0] : '0;
        end
        EXEC: if (it == 2'b11) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          state <= FETCH;
          pc <= (it == 2'b10 && cond == ir[INSTR_W-3]) ? ir[PC_W-1:0] : pc + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed self-checking bench for micro_sequencer
module tb_micro_sequencer;
  logic clk = 0, reset = 1, start = 0, cond = 0, prog_we = 0;
  logic [4:0] prog_addr = 0;
  logic [14:0] prog_wdata = 0;
  logic busy, done, RFSrcMuxSel, writeEn, outBuf;
  logic [4:0] pc;
  logic [2:0] readAddr1, readAddr2, writeAddr, aluOP;
  int total = 0, bad = 0;
  micro_sequencer dut (.clk(clk), .reset(reset), .start(start), .cond(cond), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy), .done(done), .pc(pc),
    .RFSrcMuxSel(RFSrcMuxSel), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .writeAddr(writeAddr), .writeEn(writeEn), .outBuf(outBuf), .aluOP(aluOP));
  always #5 clk = ~clk;
  function automatic logic [14:0] ex(input logic m, input logic [2:0] a1, a2, wa, op);
    return {2'b00, m, a1, a2, wa, op};
  endfunction
  function automatic logic [14:0] sh(input logic [2:0] a1);
    return {2'b01, 1'b0, a1, 9'd0};
  endfunction
  function automatic logic [14:0] br(input logic p, input logic [4:0] t);
    return {2'b10, p, 7'd0, t};
  endfunction
  localparam logic [14:0] HALT = {2'b11, 13'd0};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [4:0] a, input logic [14:0] d);
    prog_we = 1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 0;
  endtask
  task automatic load_basic();
    load(0, ex(1, 0, 0, 1, 0));
    load(1, ex(0, 1, 1, 4, 0));
    load(2, sh(4));
    load(3, HALT);
  endtask
  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic test_reset();
    load_basic();
    go();
    tick(); tick();
    reset = 1;
    tick(); tick();
    reset = 0;
    total++; if (busy !== 0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if (done !== 0) begin bad++; $display("FAIL reset_done got=%0h want=0", done); end
    total++; if (pc !== 0) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc); end
    total++; if ({writeEn, outBuf, aluOP, writeAddr} !== 0) begin bad++;
      $display("FAIL reset_ctrl got=%0h want=0", {writeEn, outBuf, aluOP, writeAddr}); end
    tick();
    total++; if (busy !== 0) begin bad++; $display("FAIL reset_stays_idle got=%0h want=0", busy); end
  endtask
  task automatic test_basic();
    int nwe = 0;
    go();
    for (int c = 1; c <= 11; c++) begin
      nwe += writeEn;
      if (c == 1) begin total++; if (busy !== 1 || writeEn !== 0) begin bad++;
        $display("FAIL basic_fetch got=%0h want=2", {busy, writeEn}); end end
      if (c == 2) begin total++; if ({writeEn, writeAddr, RFSrcMuxSel, pc} !== {1'b1, 3'd1, 1'b1, 5'd0}) begin bad++;
        $display("FAIL basic_c2 got=%0h want=%0h", {writeEn, writeAddr, RFSrcMuxSel, pc}, {1'b1, 3'd1, 1'b1, 5'd0}); end end
      if (c == 4) begin total++; if ({writeEn, writeAddr, readAddr1, readAddr2, RFSrcMuxSel} !== {1'b1, 3'd4, 3'd1, 3'd1, 1'b0}) begin bad++;
        $display("FAIL basic_c4 got=%0h want=%0h", {writeEn, writeAddr, readAddr1, readAddr2, RFSrcMuxSel}, {1'b1, 3'd4, 3'd1, 3'd1, 1'b0}); end end
      if (c == 6) begin total++; if ({outBuf, readAddr1, writeEn, readAddr2} !== {1'b1, 3'd4, 1'b0, 3'd0}) begin bad++;
        $display("FAIL basic_show got=%0h want=%0h", {outBuf, readAddr1, writeEn, readAddr2}, {1'b1, 3'd4, 1'b0, 3'd0}); end end
      if (c == 8) begin total++; if ({done, busy, outBuf} !== 3'b010) begin bad++;
        $display("FAIL basic_halt_exec got=%0h want=2", {done, busy, outBuf}); end end
      if (c == 9) begin total++; if ({done, busy} !== 2'b10) begin bad++;
        $display("FAIL basic_done got=%0h want=2", {done, busy}); end end
      if (c == 10) begin total++; if (done !== 0) begin bad++;
        $display("FAIL basic_done_pulse got=%0h want=0", done); end end
      tick();
    end
    total++; if (nwe !== 2) begin bad++; $display("FAIL basic_we_count got=%0d want=2", nwe); end
  endtask
  task automatic test_branch_loop();
    int body = 0, dc = 0;
    load(0, ex(0, 0, 0, 1, 0));
    load(1, ex(0, 0, 0, 2, 5));
    load(2, br(1, 1));
    load(3, HALT);
    cond = 1;
    go();
    for (int c = 1; c <= 40; c++) begin
      if (writeEn && writeAddr == 2) body++;
      if (done && dc == 0) dc = c;
      cond = body < 3;
      tick();
    end
    cond = 0;
    total++; if (body !== 3) begin bad++; $display("FAIL loop_body got=%0d want=3", body); end
    total++; if (dc !== 17) begin bad++; $display("FAIL loop_done_cycle got=%0d want=17", dc); end
  endtask
  task automatic test_branch_neg();
    load(0, br(0, 5));
    load(1, HALT);
    load(5, ex(0, 0, 0, 3, 0));
    load(6, HALT);
    for (int k = 0; k < 2; k++) begin
      cond = k[0];
      go();
      for (int c = 1; c <= 9; c++) begin
        if (c == 2) begin total++; if ({writeEn, outBuf, aluOP, readAddr1} !== 0) begin bad++;
          $display("FAIL neg_branch_outs got=%0h want=0", {writeEn, outBuf, aluOP, readAddr1}); end end
        if (c == 4) begin total++;
          if ({pc, writeEn} !== (k == 0 ? {5'd5, 1'b1} : {5'd1, 1'b0})) begin bad++;
            $display("FAIL neg_k%0d got=%0h want=%0h", k, {pc, writeEn}, (k == 0 ? {5'd5, 1'b1} : {5'd1, 1'b0})); end end
        tick();
      end
    end
    cond = 0;
  endtask
  task automatic test_wrap();
    int low = 0;
    for (int i = 0; i < 32; i++) load(i[4:0], ex(i[0], 0, 0, i[2:0], 1));
    go();
    for (int c = 1; c <= 70; c++) begin
      if (!busy) low++;
      if (c == 64) begin total++; if ({pc, writeAddr} !== {5'd31, 3'd7}) begin bad++;
        $display("FAIL wrap_c64 got=%0h want=%0h", {pc, writeAddr}, {5'd31, 3'd7}); end end
      if (c == 66) begin total++; if ({pc, writeAddr, writeEn} !== {5'd0, 3'd0, 1'b1}) begin bad++;
        $display("FAIL wrap_c66 got=%0h want=%0h", {pc, writeAddr, writeEn}, {5'd0, 3'd0, 1'b1}); end end
      tick();
    end
    total++; if (low !== 0) begin bad++; $display("FAIL wrap_busy got=%0d want=0", low); end
    reset = 1; tick(); reset = 0;
  endtask
  task automatic test_back_to_back();
    logic [4:0] exp_pc [4] = '{0, 1, 2, 3};
    load_basic();
    go();
    for (int c = 1; c <= 11; c++) begin
      if (c % 2 == 0 && c <= 8) begin total++; if (pc !== exp_pc[c/2-1]) begin bad++;
        $display("FAIL b2b_pc_c%0d got=%0d want=%0d", c, pc, exp_pc[c/2-1]); end end
      if (c == 6) begin total++; if ({outBuf, readAddr1} !== {1'b1, 3'd4}) begin bad++;
        $display("FAIL b2b_show got=%0h want=c", {outBuf, readAddr1}); end end
      if (c == 9) begin total++; if (done !== 1) begin bad++; $display("FAIL b2b_done got=%0h want=1", done); end end
      if (c == 11) begin total++; if (busy !== 0) begin bad++; $display("FAIL b2b_done_start got=%0h want=0", busy); end end
      prog_we = c <= 5; prog_addr = 2; prog_wdata = HALT;
      start = c == 3 || c == 9;
      tick();
    end
    prog_we = 0; start = 0;
    go();
    for (int c = 1; c <= 10; c++) begin
      if (c == 6) begin total++; if ({outBuf, readAddr1} !== {1'b1, 3'd4}) begin bad++;
        $display("FAIL b2b_rerun_mem got=%0h want=c", {outBuf, readAddr1}); end end
      tick();
    end
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    test_reset();
    test_basic();
    test_branch_loop();
    test_branch_neg();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
